gauss_stream_ctrl: RTL and testbench

GAUSS_STREAM_CTRL -- requirements
Module: gauss_stream_ctrl

---
 rtl/gauss_stream_ctrl.sv | 149 ++++++++++++++
 tb/tb_gauss_stream_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gauss_stream_ctrl.sv
// Frame sequencer between an AXI-Stream pixel source/sink and a fixed-latency Gaussian core.
// Owns the core reset/stall, the frame counters and a 4-deep output FIFO that absorbs sink backpressure.
module gauss_stream_ctrl #(
    parameter int PIXELS_PER_BEAT = 16,
    parameter int INPUT_WIDTH     = 8,
    parameter int IMAGE_DIM       = 512,
    parameter int CORE_LATENCY    = IMAGE_DIM / PIXELS_PER_BEAT + 2,
    localparam int DATA_WIDTH     = INPUT_WIDTH * PIXELS_PER_BEAT
) (
    input  logic                  clk,
    input  logic                  areset,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tuser,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tuser,
    output logic                  m_axis_tlast,
    output logic                  core_aresetn,
    output logic                  core_stall,
    output logic [DATA_WIDTH-1:0] core_inp_frame,
    input  logic [DATA_WIDTH-1:0] core_out_frame,
    output logic                  busy,
    output logic                  err_sof,
    output logic                  err_eol
);

    localparam int BPR         = IMAGE_DIM / PIXELS_PER_BEAT;
    localparam int TOTAL_BEATS = IMAGE_DIM * BPR;
    localparam int CW          = $clog2(TOTAL_BEATS + CORE_LATENCY + 1);

    localparam logic [CW-1:0] BPR_C    = CW'(BPR);
    localparam logic [CW-1:0] ROW_LAST = CW'(BPR - 1);
    localparam logic [CW-1:0] LAST_IN  = CW'(TOTAL_BEATS - 1);
    localparam logic [CW-1:0] LAST_ADV = CW'(TOTAL_BEATS + CORE_LATENCY - 1);
    localparam logic [CW-1:0] LAT_C    = CW'(CORE_LATENCY);

    typedef enum logic [2:0] {IDLE, CLEAR, RUN, FLUSH, DRAIN} state_t;

    state_t                state;
    logic [CW-1:0]         in_cnt;
    logic [CW-1:0]         adv_cnt;
    logic [CW-1:0]         out_cnt;
    logic                  push_pending;
    logic [DATA_WIDTH+1:0] fifo_mem [4];
    logic [1:0]            wr_ptr;
    logic [1:0]            rd_ptr;
    logic [2:0]            fifo_count;
    logic                  credit;
    logic                  adv;
    logic                  pop;
    logic                  in_row_end;

    // An advance now lands in the FIFO two cycles later, so keep room for everything in flight.
    assign credit = (fifo_count + 3'(push_pending)) <= 3'd2;

    always_comb begin
        adv = 1'b0;
        if (!areset) begin
            case (state)
                RUN:     adv = s_axis_tvalid & credit;
                FLUSH:   adv = credit;
                default: adv = 1'b0;
            endcase
        end
    end

    assign core_stall     = ~adv;
    assign s_axis_tready  = (state == RUN) & adv;
    assign core_inp_frame = (state == RUN) ? s_axis_tdata : '0;
    assign core_aresetn   = ~areset & (state != CLEAR);
    assign busy           = (state != IDLE);
    assign in_row_end     = (in_cnt % BPR_C) == ROW_LAST;

    assign m_axis_tvalid = (fifo_count != 3'd0);
    assign pop           = m_axis_tvalid & m_axis_tready;
    assign {m_axis_tuser, m_axis_tlast, m_axis_tdata} = m_axis_tvalid ? fifo_mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (areset) begin
            state        <= IDLE;
            in_cnt       <= '0;
            adv_cnt      <= '0;
            out_cnt      <= '0;
            push_pending <= 1'b0;
            err_sof      <= 1'b0;
            err_eol      <= 1'b0;
        end else begin
            push_pending <= adv && (adv_cnt >= LAT_C);
            if (push_pending) out_cnt <= out_cnt + 1'b1;
            if (adv) adv_cnt <= adv_cnt + 1'b1;
            case (state)
                IDLE: begin
                    if (s_axis_tvalid && s_axis_tuser) state <= CLEAR;
                end
                CLEAR: begin
                    in_cnt  <= '0;
                    adv_cnt <= '0;
                    out_cnt <= '0;
                    err_sof <= 1'b0;
                    err_eol <= 1'b0;
                    state   <= RUN;
                end
                RUN: begin
                    if (adv) begin
                        in_cnt <= in_cnt + 1'b1;
                        if (s_axis_tuser && (in_cnt != '0)) err_sof <= 1'b1;
                        if (s_axis_tlast != in_row_end) err_eol <= 1'b1;
                        if (in_cnt == LAST_IN) state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (adv && (adv_cnt == LAST_ADV)) state <= DRAIN;
                end
                DRAIN: begin
                    if ((fifo_count == 3'd0) && !push_pending) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Frame markers are derived from the output beat index and stored with the pixel data.
    always_ff @(posedge clk) begin
        if (push_pending) begin
            fifo_mem[wr_ptr] <= {out_cnt == '0, (out_cnt % BPR_C) == ROW_LAST, core_out_frame};
        end
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            wr_ptr     <= 2'd0;
            rd_ptr     <= 2'd0;
            fifo_count <= 3'd0;
        end else begin
            if (push_pending) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push_pending, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_gauss_stream_ctrl.sv
// Randomized scoreboard bench for gauss_stream_ctrl on a 32x32 frame, 16 pixels per beat.
// A stand-in core zeroes the first two rows and passes the rest through after its latency.
module tb_gauss_stream_ctrl;

    localparam int PPB   = 16;
    localparam int IW    = 8;
    localparam int DIM   = 32;
    localparam int LAT   = 4;
    localparam int DW    = PPB * IW;
    localparam int BPR   = DIM / PPB;
    localparam int TOTAL = DIM * BPR;

    logic          clk;
    logic          areset;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tuser;
    logic          s_axis_tlast;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tuser;
    logic          m_axis_tlast;
    logic          core_aresetn;
    logic          core_stall;
    logic [DW-1:0] core_inp_frame;
    logic [DW-1:0] core_out_frame;
    logic          busy;
    logic          err_sof;
    logic          err_eol;

    gauss_stream_ctrl #(
        .PIXELS_PER_BEAT(PPB),
        .INPUT_WIDTH(IW),
        .IMAGE_DIM(DIM),
        .CORE_LATENCY(LAT)
    ) dut (
        .clk(clk),
        .areset(areset),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tuser(s_axis_tuser),
        .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tuser(m_axis_tuser),
        .m_axis_tlast(m_axis_tlast),
        .core_aresetn(core_aresetn),
        .core_stall(core_stall),
        .core_inp_frame(core_inp_frame),
        .core_out_frame(core_out_frame),
        .busy(busy),
        .err_sof(err_sof),
        .err_eol(err_eol)
    );

    int             checks_total = 0;
    int             checks_passed = 0;
    int             accepted = 0;
    int             frame_out = 0;
    int             ready_mode = 0;
    logic [DW+1:0]  exp_q [$];
    logic [DW-1:0]  core_pipe [LAT];
    int             core_idx;
    logic           prev_hold = 1'b0;
    logic [DW+2:0]  prev_beat = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [159:0] actual, input logic [159:0] expected);
        checks_total++;
        if (actual === expected) checks_passed++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    task automatic noteFail(input string name);
        checks_total++;
        $display("[TB] FAIL %s: bound expired, got timeout, expected completion", name);
    endtask

    // Stand-in Gaussian core: output beat k is zero for the first two rows, else input beat k.
    always @(posedge clk) begin
        if (!core_aresetn) begin
            for (int i = 0; i < LAT; i++) core_pipe[i] <= '0;
            core_out_frame <= '0;
            core_idx       <= 0;
        end else if (!core_stall) begin
            core_pipe[0] <= (core_idx >= 2 * BPR) ? core_inp_frame : '0;
            for (int i = 1; i < LAT; i++) core_pipe[i] <= core_pipe[i-1];
            core_out_frame <= core_pipe[LAT-1];
            core_idx       <= core_idx + 1;
        end
    end

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = 1'($urandom_range(1));
            default: m_axis_tready = 1'b0;
        endcase
    end

    // Monitor: pops the scoreboard on every output handshake and checks hold stability.
    always @(negedge clk) begin
        logic [DW+1:0] exp_beat;
        if (areset) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold)
                checkOutput("hold_stable", {m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata}, prev_beat);
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    checks_total++;
                    $display("[TB] FAIL unexpected_beat: got %0h, expected no beat", m_axis_tdata);
                end else begin
                    exp_beat = exp_q.pop_front();
                    checkOutput("out_beat", {m_axis_tuser, m_axis_tlast, m_axis_tdata}, exp_beat);
                end
                frame_out++;
            end
            prev_hold = m_axis_tvalid && !m_axis_tready;
            prev_beat = {m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata};
        end
    end

    // Sends one frame; expected output for each accepted beat is queued at acceptance.
    task automatic applyStimulus(input int pct, input int sof_beat, input int no_eol_beat,
                                 input int abort_at, input bit const_data);
        logic [DW-1:0] d;
        bit            done;
        int            waited;
        accepted = 0;
        for (int k = 0; k < TOTAL; k++) begin
            if (k == abort_at) break;
            while ($urandom_range(99) >= pct) begin
                s_axis_tvalid = 1'b0;
                @(posedge clk);
                #1;
            end
            d = const_data ? {PPB{8'h80}} : {$urandom, $urandom, $urandom, $urandom};
            s_axis_tdata  = d;
            s_axis_tvalid = 1'b1;
            s_axis_tuser  = (k == 0) || (k == sof_beat);
            s_axis_tlast  = (k % BPR == BPR - 1) && (k != no_eol_beat);
            done   = 1'b0;
            waited = 0;
            while (!done && waited < 2000) begin
                @(negedge clk);
                if (s_axis_tready) begin
                    exp_q.push_back({1'(k == 0), 1'(k % BPR == BPR - 1), (k >= 2 * BPR) ? d : {DW{1'b0}}});
                    accepted++;
                    done = 1'b1;
                end
                @(posedge clk);
                #1;
                waited++;
            end
            if (!done) begin
                noteFail("accept_timeout");
                break;
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic applyReset();
        areset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_s_tready", s_axis_tready, 0);
        checkOutput("rst_m_outputs", {m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata}, 0);
        checkOutput("rst_core", {core_aresetn, core_stall}, 2'b01);
        checkOutput("rst_status", {busy, err_sof, err_eol}, 0);
        @(posedge clk);
        #1;
        areset = 1'b0;
        @(negedge clk);
        checkOutput("idle_core_aresetn", core_aresetn, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || exp_q.size() != 0) && n < 4000);
        if (busy || exp_q.size() != 0) noteFail(name);
        @(posedge clk);
        #1;
    endtask

    task automatic runFrame(input string name, input int pct, input int sof_beat,
                            input int no_eol_beat, input bit const_data);
        frame_out = 0;
        applyStimulus(pct, sof_beat, no_eol_beat, -1, const_data);
        waitIdle(name);
        checkOutput({name, "_out_count"}, frame_out, TOTAL);
        checkOutput({name, "_busy"}, busy, 0);
    endtask

    initial begin
        areset        = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;
        @(posedge clk);
        #1;
        applyReset();

        // Back-to-back frame with an always-ready sink.
        ready_mode = 0;
        runFrame("b2b", 100, -1, -1, 1'b0);
        checkOutput("b2b_errs", {err_sof, err_eol}, 0);

        // Beat held in IDLE without start-of-frame is never consumed.
        s_axis_tvalid = 1'b1;
        s_axis_tuser  = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("idle_no_sof_tready", s_axis_tready, 0);
        checkOutput("idle_no_sof_busy", busy, 0);
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;

        // Sink stalled from the start: pipeline must fill and then hold.
        ready_mode = 2;
        frame_out  = 0;
        fork
            applyStimulus(100, -1, -1, -1, 1'b0);
        join_none
        repeat (300) @(posedge clk);
        @(negedge clk);
        checkOutput("stall_core_stall", core_stall, 1);
        checkOutput("stall_s_tready", s_axis_tready, 0);
        checkOutput("stall_m_tvalid", m_axis_tvalid, 1);
        checkOutput("stall_buffered_bound", accepted <= LAT + 4, 1);
        checkOutput("stall_no_output", frame_out, 0);
        ready_mode = 0;
        wait fork;
        waitIdle("stall");
        checkOutput("stall_out_count", frame_out, TOTAL);

        // Constant mid-grey image.
        runFrame("const80", 100, -1, -1, 1'b1);

        // Misplaced start-of-frame is sticky until the next frame clears it.
        runFrame("sof_err", 100, 5, -1, 1'b0);
        checkOutput("sof_err_flags", {err_sof, err_eol}, 2'b10);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("sof_err_sticky", err_sof, 1);
        runFrame("eol_err", 100, -1, 1, 1'b0);
        checkOutput("eol_err_flags", {err_sof, err_eol}, 2'b01);
        runFrame("clean", 100, -1, -1, 1'b0);
        checkOutput("clean_flags", {err_sof, err_eol}, 0);

        // Reset in the middle of a frame discards it.
        ready_mode = 1;
        applyStimulus(100, -1, -1, 30, 1'b0);
        frame_out = 0;
        applyReset();
        repeat (40) @(posedge clk);
        @(negedge clk);
        checkOutput("post_rst_quiet", {m_axis_tvalid, busy}, 0);
        checkOutput("post_rst_no_beats", frame_out, 0);
        @(posedge clk);
        #1;
        runFrame("after_rst", 100, -1, -1, 1'b0);

        // Random source and sink throttling.
        ready_mode = 1;
        runFrame("rand_a", 50, -1, -1, 1'b0);
        runFrame("rand_b", 50, -1, -1, 1'b0);
        checkOutput("rand_errs", {err_sof, err_eol}, 0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
